rob_param: RTL

//  Parametrised reorder buffer, the next generation of the in-order commit queue.

---
 rtl/rob_param.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer. Tags are allocated in program order. Results arrive out
// of order on NUM_WB write-back ports. Dispatch looks up operands on NUM_QRY ports.
// The head entry retires in order under a valid/ready handshake.
module rob_param #(
    parameter int unsigned ROB_SIZE_W = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_WB     = 2,
    parameter int unsigned NUM_QRY    = 2,
    localparam int unsigned TAG_W     = ROB_SIZE_W + 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        push_valid,
    input  logic [31:0]                 push_src_addr,
    input  logic [4:0]                  push_rd_idx,
    output logic                        push_ready,
    output logic [TAG_W-1:0]            push_rob_tag,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
    input  logic [NUM_WB*DATA_W-1:0]    wb_val,
    input  logic [NUM_QRY*TAG_W-1:0]    qry_tag,
    output logic [NUM_QRY-1:0]          qry_ready,
    output logic [NUM_QRY*DATA_W-1:0]   qry_val,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [TAG_W-1:0]            commit_tag,
    output logic [DATA_W-1:0]           commit_val,
    output logic [31:0]                 commit_addr,
    output logic [4:0]                  commit_rd_idx,
    output logic [ROB_SIZE_W:0]         count
);

    localparam int unsigned      DEPTH     = 1 << ROB_SIZE_W;
    localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);

    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [DATA_W-1:0]     val_q  [DEPTH];
    logic [DATA_W-1:0]     val_d  [DEPTH];
    logic [31:0]           addr_q [DEPTH];
    logic [31:0]           addr_d [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [4:0]            rd_d   [DEPTH];
    logic [ROB_SIZE_W-1:0] head_q, head_d;
    logic [ROB_SIZE_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0]      count_q, count_d;

    logic                  push_fire;
    logic                  commit_fire;
    logic [NUM_WB-1:0]     wb_apply;
    logic [ROB_SIZE_W-1:0] wb_idx  [NUM_WB];
    logic [ROB_SIZE_W-1:0] qry_idx [NUM_QRY];
    logic [TAG_W-1:0]      qry_t   [NUM_QRY];

    // Tag 0 means "none"; tags above DEPTH name no slot.
    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= DEPTH_TAG);
    endfunction

    function automatic logic [ROB_SIZE_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        return ROB_SIZE_W'(t - TAG_W'(1));
    endfunction

    // Handshake and head-of-queue outputs.
    always_comb begin
        push_ready    = rst_in && rdy_in && (count_q != DEPTH_TAG);
        push_fire     = push_valid && push_ready && !flush_in;
        push_rob_tag  = push_valid ? (TAG_W'(tail_q) + TAG_W'(1)) : '0;
        commit_valid  = rst_in && rdy_in && !flush_in && busy_q[head_q] && done_q[head_q];
        commit_fire   = commit_valid && commit_ready;
        commit_tag    = TAG_W'(head_q) + TAG_W'(1);
        commit_val    = val_q[head_q];
        commit_addr   = addr_q[head_q];
        commit_rd_idx = rd_q[head_q];
        count         = count_q;
    end

    // Decode which write-back ports land on a live, still-pending slot.
    always_comb begin
        wb_apply = '0;
        for (int i = 0; i < int'(NUM_WB); i++) begin
            wb_idx[i]   = tag_idx(wb_tag[i*TAG_W +: TAG_W]);
            wb_apply[i] = wb_valid[i] && tag_ok(wb_tag[i*TAG_W +: TAG_W]) &&
                          busy_q[wb_idx[i]] && !done_q[wb_idx[i]];
        end
    end

    // Operand lookup: stored value first, else same-cycle bypass from write-back.
    always_comb begin
        qry_ready = '0;
        qry_val   = '0;
        for (int q = 0; q < int'(NUM_QRY); q++) begin
            qry_t[q]   = qry_tag[q*TAG_W +: TAG_W];
            qry_idx[q] = tag_idx(qry_t[q]);
            if (rst_in && tag_ok(qry_t[q]) && busy_q[qry_idx[q]]) begin
                if (done_q[qry_idx[q]]) begin
                    qry_ready[q]                 = 1'b1;
                    qry_val[q*DATA_W +: DATA_W]  = val_q[qry_idx[q]];
                end else begin
                    // Descending scan so the lowest port index wins.
                    for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
                        if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == qry_t[q])) begin
                            qry_ready[q]                = 1'b1;
                            qry_val[q*DATA_W +: DATA_W] = wb_val[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    // Next-state: flush clears everything, otherwise write-back, retire and allocate.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        val_d   = val_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (flush_in) begin
                busy_d  = '0;
                done_d  = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                // Descending so the lowest port index writes last and wins.
                for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
                    if (wb_apply[i]) begin
                        done_d[wb_idx[i]] = 1'b1;
                        val_d[wb_idx[i]]  = wb_val[i*DATA_W +: DATA_W];
                    end
                end
                if (commit_fire) begin
                    busy_d[head_q] = 1'b0;
                    done_d[head_q] = 1'b0;
                    head_d         = head_q + ROB_SIZE_W'(1);
                end
                // Not full, so tail never aliases the head being retired.
                if (push_fire) begin
                    busy_d[tail_q] = 1'b1;
                    done_d[tail_q] = 1'b0;
                    val_d[tail_q]  = '0;
                    addr_d[tail_q] = push_src_addr;
                    rd_d[tail_q]   = push_rd_idx;
                    tail_d         = tail_q + ROB_SIZE_W'(1);
                end
                count_d = count_q + TAG_W'(push_fire) - TAG_W'(commit_fire);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                val_q[k]  <= '0;
                addr_q[k] <= '0;
                rd_q[k]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            val_q   <= val_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
